// File: rtl/nrisc_ula_seq.sv
// ============================================================================
// Module   : nrisc_ula_seq
// Purpose  : Issue/capture sequencer in front of the NRISC ULA; iterates
//            single-bit shifts and hands results to register-file writeback.
//            Option macro: NRISC_ULA_SEQ_ZEROFIX_EN (local zero-flag recompute).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nrisc_ula_seq #(
  parameter int TAM     = 16,
  parameter int RADDR_W = 3,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [3:0]         op_ctrl,
  input  logic [TAM-1:0]     op_a,
  input  logic [TAM-1:0]     op_b,
  input  logic [RADDR_W-1:0] op_rd,
  input  logic [CNT_W-1:0]   op_cnt,
  output logic [TAM-1:0]     ula_a,
  output logic [TAM-1:0]     ula_b,
  output logic [3:0]         ula_ctrl,
  input  logic [TAM-1:0]     ula_out,
  input  logic [2:0]         ula_flags,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [TAM-1:0]     wb_data,
  output logic [2:0]         wb_flags,
  output logic [2:0]         flags,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TAM-1:0]       ula_a_q, ula_a_d;
  logic [TAM-1:0]       ula_b_q, ula_b_d;
  logic [3:0]           ula_ctrl_q, ula_ctrl_d;
  logic [RADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic [TAM-1:0]       wb_data_q, wb_data_d;
  logic [2:0]           wb_flags_q, wb_flags_d;
  logic [2:0]           flags_q, flags_d;
  logic [CNT_W-1:0]     rem_q, rem_d;

  logic                 w_is_shift;
  logic [CNT_W-1:0]     w_load_cnt;
  logic [2:0]           w_capt_flags;

  assign w_is_shift = (op_ctrl[2:0] == 3'b101) || (op_ctrl[2:0] == 3'b110);
  // A zero count still performs one pass; non-shift ops always take one pass.
  assign w_load_cnt = (w_is_shift && (op_cnt != '0)) ? op_cnt : CNT_W'(1);

`ifdef NRISC_ULA_SEQ_ZEROFIX_EN
  assign w_capt_flags = {ula_flags[2], (ula_out == '0), ula_flags[0]};
`else
  assign w_capt_flags = ula_flags;
`endif

  always_comb begin
    state_d    = state_q;
    ula_a_d    = ula_a_q;
    ula_b_d    = ula_b_q;
    ula_ctrl_d = ula_ctrl_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_flags_d = wb_flags_q;
    flags_d    = flags_q;
    rem_d      = rem_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          ula_a_d    = op_a;
          ula_b_d    = op_b;
          ula_ctrl_d = op_ctrl;
          wb_rd_d    = op_rd;
          rem_d      = w_load_cnt;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPT;
      S_CAPT: begin
        // Feed the partial result back as the next single-bit step's operand.
        if (rem_q > CNT_W'(1)) begin
          ula_a_d = ula_out;
          rem_d   = rem_q - CNT_W'(1);
          state_d = S_ISSUE;
        end else begin
          wb_data_d  = ula_out;
          wb_flags_d = w_capt_flags;
          state_d    = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          flags_d = wb_flags_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ula_a_q    <= '0;
      ula_b_q    <= '0;
      ula_ctrl_q <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      flags_q    <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      ula_a_q    <= ula_a_d;
      ula_b_q    <= ula_b_d;
      ula_ctrl_q <= ula_ctrl_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
      flags_q    <= flags_d;
      rem_q      <= rem_d;
    end
  end

  assign op_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_WB);
  assign ula_a    = ula_a_q;
  assign ula_b    = ula_b_q;
  assign ula_ctrl = ula_ctrl_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_flags = wb_flags_q;
  assign flags    = flags_q;

endmodule

`default_nettype wire

// File: doc/nrisc_ula_seq.md
Name: nrisc_ula_seq

Overview:
- Sequencer directly upstream of the NRISC ULA.
- Accepts decoded ALU operations over a valid/ready handshake and drives ULA_A/ULA_B/ULA_ctrl.
- Waits out the ULA's one-cycle registered latency and captures ULA_OUT/ULA_flags.
- Iterates single-bit shift/rotate ops to give multi-bit shifts, then presents result, destination and flags to register-file writeback with valid/ready; holds the architectural flags register.

Parameters:
TAM, 16, datapath width (matches ULA TAM)
RADDR_W, 3, destination register index width
CNT_W, 4, shift/rotate repeat-count width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
op_valid  in  1  operation offered
op_ready  out  1  sequencer can accept (high only in IDLE)
op_ctrl  in  4  ULA control code: bit3 = 0 shift / 1 rotate; bits2:0 = 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 right shift/rotate, 110 left shift/rotate, 111 not
op_a  in  TAM  operand A
op_b  in  TAM  operand B
op_rd  in  RADDR_W  destination register index
op_cnt  in  CNT_W  repeat count for ctrl[2:0] = 101/110; ignored otherwise
ula_a  out  TAM  to ULA_A
ula_b  out  TAM  to ULA_B
ula_ctrl  out  4  to ULA_ctrl
ula_out  in  TAM  from ULA_OUT
ula_flags  in  3  from ULA_flags {minus, zero, carry}
wb_valid  out  1  writeback result valid
wb_ready  in  1  register file accepts writeback
wb_rd  out  RADDR_W  destination index
wb_data  out  TAM  result
wb_flags  out  3  {minus, zero, carry} of this result
flags  out  3  architectural flags register
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst high at a clock edge forces state IDLE, regardless of current state. An in-flight op is discarded with no writeback.
- Reset values: all outputs 0 except op_ready = 1, i.e. ula_a, ula_b, ula_ctrl, wb_*, flags and busy = 0.
- States: IDLE, ISSUE, CAPT, WB.
- IDLE:
  - op_ready = 1.
  - On op_valid & op_ready: latch op_a→ula_a, op_b→ula_b, op_ctrl→ula_ctrl, op_rd→wb_rd.
  - Load remaining count rem: op_cnt, with op_cnt = 0 treated as 1; rem = 1 for non-shift ops.
  - Next state ISSUE.
- ISSUE:
  - ula_a/ula_b/ula_ctrl held stable; the ULA registers its result at the closing edge.
  - Next state CAPT.
- CAPT: ula_out/ula_flags are valid this cycle.
  - If rem > 1: ula_a <= ula_out, rem <= rem - 1, ula_b and ula_ctrl unchanged, next ISSUE.
  - Else: wb_data <= ula_out, wb_flags <= ula_flags, next WB.
- WB:
  - wb_valid = 1; wb_rd/wb_data/wb_flags held stable until wb_ready.
  - On wb_valid & wb_ready: flags <= wb_flags, wb_valid <= 0, next IDLE.
- Latency: wb_valid rises 2·N cycles after the accepting edge (N = effective repeat count); minimum 2.
- Throughput: one op in flight; op_ready is 0 from the accept edge until the cycle after the writeback handshake. No back-to-back overlap.
- Flags:
  - For multi-bit shifts, wb_flags come from the final iteration only; carry is not accumulated.
  - The flags register changes only on the writeback handshake.
- Count width: op_cnt at maximum (2^CNT_W - 1) gives exactly that many iterations; rem never wraps.
- op_valid while busy: ignored. The upstream stage holds the op until op_ready.

Optional Feature:
- Macro NRISC_ULA_SEQ_ZEROFIX_EN.
- Defined: wb_flags[1] is recomputed locally in CAPT as (ula_out == 0); bits 2 and 0 are passed through.
- Not defined: all three bits are passed through from ula_flags unchanged.

Test Plan:
1. Add: op_ctrl=0000, A=0x7FFF, B=0x0001, rd=3 → ula_* driven from cycle after accept; wb_valid 2 cycles after accept; wb_data=0x8000, wb_rd=3, wb_flags = ula_flags sampled in CAPT; flags updated on handshake.
2. Multi-shift: op_ctrl=0110, A=0x0001, cnt=3 → ula_a sequence 0x0001, 0x0002, 0x0004; wb_data=0x0008 after 6 cycles; ula_ctrl held 0110 throughout.
3. Rotate with cnt=0: op_ctrl=1101, A=0x0001, cnt=0 → single iteration; wb_data=0x8000 after 2 cycles.
4. Backpressure: wb_ready low 5 cycles after wb_valid → wb_valid/wb_data/wb_rd stable, op_ready=0, flags unchanged; wb_ready high → flags updated next edge, op_ready=1 following cycle.
5. Reset mid-op: rst=1 during second ISSUE of a cnt=4 shift → next cycle IDLE, op_ready=1, all other outputs 0, no wb_valid pulse.
6. Zero fix: stub ULA returns ula_out=0x0005 with ula_flags=3'b010 → wb_flags=3'b000 with NRISC_ULA_SEQ_ZEROFIX_EN, 3'b010 without; ula_out=0x0000 with ula_flags=3'b000 → 3'b010 with macro, 3'b000 without.
